// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU control codes,
// opcode/funct values and skid buffer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_NE   = 4'd8;
  localparam logic [3:0] ALU_GT   = 4'd9;
  localparam logic [3:0] ALU_GE   = 4'd10;
  localparam logic [3:0] ALU_LT   = 4'd11;
  localparam logic [3:0] ALU_LE   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLE   = 6'h06;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BGE   = 6'h14;
  localparam logic [5:0] OP_BLT   = 6'h15;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/alu_op_encoder.sv
// Combinational ALU control/operand encoder.
// In: opcode/funct/shamt/imm/rs/rt. Out: code, a, b, is_branch, illegal.
module alu_op_encoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic [4:0]      shamt,
  input  logic [15:0]     imm,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic [3:0]      code,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic            is_branch,
  output logic            illegal
);

  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_zext;
  logic [XLEN-1:0] sh_zext;

  assign imm_sext = {{(XLEN-16){imm[15]}}, imm};
  assign imm_zext = {{(XLEN-16){1'b0}}, imm};
  assign sh_zext  = {{(XLEN-5){1'b0}}, shamt};

  always_comb begin
    code      = ALU_ADD;
    a         = rs_data;
    b         = rt_data;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_AND:           code = ALU_AND;
          FN_OR:            code = ALU_OR;
          FN_ADD, FN_ADDU:  code = ALU_ADD;
          FN_SUB, FN_SUBU:  code = ALU_SUB;
          // SLT runs unsigned: known limitation
          FN_SLT, FN_SLTU:  code = ALU_SLTU;
          FN_NOR:           code = ALU_NOR;
          FN_SLL: begin
            code = ALU_SLL;
            a    = rt_data;
            b    = sh_zext;
          end
          FN_SRL: begin
            code = ALU_SRL;
            a    = rt_data;
            b    = sh_zext;
          end
          default:          illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU,
      OP_LW, OP_SW: begin
        code = ALU_ADD;
        b    = imm_sext;
      end
      OP_SLTIU: begin
        code = ALU_SLTU;
        b    = imm_sext;
      end
      OP_ANDI: begin
        code = ALU_AND;
        b    = imm_zext;
      end
      OP_ORI: begin
        code = ALU_OR;
        b    = imm_zext;
      end
      OP_BEQ: begin
        code      = ALU_SUB;
        is_branch = 1'b1;
      end
      OP_BNE: begin
        code      = ALU_NE;
        is_branch = 1'b1;
      end
      OP_BGT: begin
        code      = ALU_GT;
        is_branch = 1'b1;
      end
      OP_BGE: begin
        code      = ALU_GE;
        is_branch = 1'b1;
      end
      OP_BLT: begin
        code      = ALU_LT;
        is_branch = 1'b1;
      end
      OP_BLE: begin
        code      = ALU_LE;
        is_branch = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: encodes ALU ops, 2-entry skid toward EX.
// In: clk/rst/flush, ID handshake + fields. Out: EX handshake, a/b/op/flags.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic [4:0]      shamt,
  input  logic [15:0]     imm,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      alu_ctrl_op,
  output logic            is_branch,
  output logic            illegal
);

  logic [3:0]      enc_op;
  logic [XLEN-1:0] enc_a;
  logic [XLEN-1:0] enc_b;
  logic            enc_br;
  logic            enc_ill;

  alu_op_encoder #(.XLEN(XLEN)) u_enc (
    .opcode    (opcode),
    .funct     (funct),
    .shamt     (shamt),
    .imm       (imm),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .code      (enc_op),
    .a         (enc_a),
    .b         (enc_b),
    .is_branch (enc_br),
    .illegal   (enc_ill)
  );

  logic [1:0]      state;
  logic [XLEN-1:0] skid_a;
  logic [XLEN-1:0] skid_b;
  logic [3:0]      skid_op;
  logic            skid_br;
  logic            skid_ill;
  logic            accept;

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != ST_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      in_ready    <= 1'b1;
      a           <= '0;
      b           <= '0;
      alu_ctrl_op <= '0;
      is_branch   <= 1'b0;
      illegal     <= 1'b0;
      skid_a      <= '0;
      skid_b      <= '0;
      skid_op     <= '0;
      skid_br     <= 1'b0;
      skid_ill    <= 1'b0;
    end else if (flush) begin
      // Main/skid payloads keep old values; only validity drops
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            a           <= enc_a;
            b           <= enc_b;
            alu_ctrl_op <= enc_op;
            is_branch   <= enc_br;
            illegal     <= enc_ill;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && out_ready) begin
            a           <= enc_a;
            b           <= enc_b;
            alu_ctrl_op <= enc_op;
            is_branch   <= enc_br;
            illegal     <= enc_ill;
          end else if (accept) begin
            skid_a   <= enc_a;
            skid_b   <= enc_b;
            skid_op  <= enc_op;
            skid_br  <= enc_br;
            skid_ill <= enc_ill;
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (out_ready) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            a           <= skid_a;
            b           <= skid_b;
            alu_ctrl_op <= skid_op;
            is_branch   <= skid_br;
            illegal     <= skid_ill;
            state       <= ST_BUSY;
            in_ready    <= 1'b1;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: vector table plus
// backpressure and flush sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl_op;
  logic        is_branch;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs[$];

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct       (funct),
    .shamt       (shamt),
    .imm         (imm),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a           (a),
    .b           (b),
    .alu_ctrl_op (alu_ctrl_op),
    .is_branch   (is_branch),
    .illegal     (illegal)
  );

  always @(posedge clk)
    if (!rst && out_valid && out_ready)
      obs.push_back(a);

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  eop;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ebr;
    logic        eill;
    logic        ez;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm,
                     input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] sh, input logic [15:0] im,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic [3:0] eop, input logic [31:0] ea,
                     input logic [31:0] eb, input logic ebr,
                     input logic eill, input logic ez);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.sh = sh; v.imm = im;
    v.rs = rs; v.rt = rt; v.eop = eop; v.ea = ea; v.eb = eb;
    v.ebr = ebr; v.eill = eill; v.ez = ez;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference ALU: z is set when the result is zero
  function automatic logic alu_z(input logic [3:0] op,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    logic [31:0] r;
    case (op)
      4'd0:    r = x & y;
      4'd1:    r = x | y;
      4'd2:    r = x + y;
      4'd3:    r = x << y[4:0];
      4'd4:    r = x >> y[4:0];
      4'd5:    r = x - y;
      4'd6:    r = {31'b0, x < y};
      4'd7:    r = ~(x | y);
      4'd8:    r = (x != y) ? 32'd0 : 32'd1;
      4'd9:    r = (x > y)  ? 32'd0 : 32'd1;
      4'd10:   r = (x >= y) ? 32'd0 : 32'd1;
      4'd11:   r = (x < y)  ? 32'd0 : 32'd1;
      4'd12:   r = (x <= y) ? 32'd0 : 32'd1;
      default: r = 32'd1;
    endcase
    return (r == 32'd0);
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt);
    opcode = op; funct = fn; shamt = 5'd0; imm = 16'd0;
    rs_data = rs; rt_data = rt; in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct = '0; shamt = '0; imm = '0;
    rs_data = '0; rt_data = '0;

    // name op fn sh imm rs rt | op a b br ill z
    add("sub",   6'h00, 6'h22, 5'd0, 16'h0000, 32'd10, 32'd3,
        4'd5, 32'd10, 32'd3, 1'b0, 1'b0, 1'b0);
    add("addi",  6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd77,
        4'd2, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    add("ori",   6'h0D, 6'h00, 5'd0, 16'hFFFF, 32'h1234, 32'd0,
        4'd1, 32'h1234, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    add("sll",   6'h00, 6'h00, 5'd4, 16'h0000, 32'h55, 32'd1,
        4'd3, 32'd1, 32'd4, 1'b0, 1'b0, 1'b0);
    add("srl",   6'h00, 6'h02, 5'd31, 16'h0000, 32'h55, 32'h80000000,
        4'd4, 32'h80000000, 32'd31, 1'b0, 1'b0, 1'b0);
    add("lw",    6'h23, 6'h00, 5'd0, 16'h8000, 32'h100, 32'd0,
        4'd2, 32'h100, 32'hFFFF8000, 1'b0, 1'b0, 1'b0);
    add("andi",  6'h0C, 6'h00, 5'd0, 16'h8000, 32'hF0F0, 32'd0,
        4'd0, 32'hF0F0, 32'h00008000, 1'b0, 1'b0, 1'b0);
    add("sltiu", 6'h0B, 6'h00, 5'd0, 16'hFFFE, 32'd2, 32'd0,
        4'd6, 32'd2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    add("nor",   6'h00, 6'h27, 5'd0, 16'h0000, 32'd6, 32'd9,
        4'd7, 32'd6, 32'd9, 1'b0, 1'b0, 1'b0);
    add("slt",   6'h00, 6'h2A, 5'd0, 16'h0000, 32'd1, 32'd2,
        4'd6, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    add("bgt",   6'h07, 6'h00, 5'd0, 16'h0000, 32'd7, 32'd9,
        4'd9, 32'd7, 32'd9, 1'b1, 1'b0, 1'b0);
    add("blt",   6'h15, 6'h00, 5'd0, 16'h0000, 32'd7, 32'd9,
        4'd11, 32'd7, 32'd9, 1'b1, 1'b0, 1'b1);
    add("beq",   6'h04, 6'h00, 5'd0, 16'h0000, 32'd4, 32'd4,
        4'd5, 32'd4, 32'd4, 1'b1, 1'b0, 1'b1);
    add("bne",   6'h05, 6'h00, 5'd0, 16'h0000, 32'd4, 32'd4,
        4'd8, 32'd4, 32'd4, 1'b1, 1'b0, 1'b0);
    add("ill_op", 6'h3F, 6'h00, 5'd0, 16'h1234, 32'd1, 32'd2,
        4'd2, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
    add("ill_fn", 6'h00, 6'h3E, 5'd0, 16'h0000, 32'd3, 32'd4,
        4'd2, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0);

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
    chk("rst_iready", {31'b0, in_ready}, 32'd1);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_op", {28'b0, alu_ctrl_op}, 32'd0);
    rst = 1'b0;

    // Vector table, one beat per cycle with out_ready=1
    foreach (tbl[i]) begin
      opcode = tbl[i].op; funct = tbl[i].fn; shamt = tbl[i].sh;
      imm = tbl[i].imm; rs_data = tbl[i].rs; rt_data = tbl[i].rt;
      in_valid = 1'b1;
      chk({tbl[i].name, "_iready"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tbl[i].name, "_ovalid"}, {31'b0, out_valid}, 32'd1);
      chk({tbl[i].name, "_op"}, {28'b0, alu_ctrl_op}, {28'b0, tbl[i].eop});
      chk({tbl[i].name, "_a"}, a, tbl[i].ea);
      chk({tbl[i].name, "_b"}, b, tbl[i].eb);
      chk({tbl[i].name, "_br"}, {31'b0, is_branch}, {31'b0, tbl[i].ebr});
      chk({tbl[i].name, "_ill"}, {31'b0, illegal}, {31'b0, tbl[i].eill});
      if (tbl[i].ebr)
        chk({tbl[i].name, "_z"}, {31'b0, alu_z(alu_ctrl_op, a, b)},
            {31'b0, tbl[i].ez});
    end
    @(posedge clk);
    @(negedge clk);
    chk("drain_ovalid", {31'b0, out_valid}, 32'd0);

    // Backpressure: three back-to-back beats, out_ready low
    obs.delete();
    out_ready = 1'b0;
    drive(6'h00, 6'h20, 32'd100, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("bp1_ovalid", {31'b0, out_valid}, 32'd1);
    chk("bp1_a", a, 32'd100);
    chk("bp1_iready", {31'b0, in_ready}, 32'd1);
    drive(6'h00, 6'h20, 32'd101, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("bp2_iready", {31'b0, in_ready}, 32'd0);
    chk("bp2_a_hold", a, 32'd100);
    drive(6'h00, 6'h20, 32'd102, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("bp3_iready", {31'b0, in_ready}, 32'd0);
    chk("bp3_a_hold", a, 32'd100);
    chk("bp3_op_hold", {28'b0, alu_ctrl_op}, 32'd2);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp4_a", a, 32'd101);
    chk("bp4_iready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("bp5_a", a, 32'd102);
    @(posedge clk); @(negedge clk);
    chk("bp6_ovalid", {31'b0, out_valid}, 32'd0);
    chk("bp6_a_kept", a, 32'd102);
    chk("bp_count", obs.size(), 32'd3);
    if (obs.size() == 3) begin
      chk("bp_ord0", obs[0], 32'd100);
      chk("bp_ord1", obs[1], 32'd101);
      chk("bp_ord2", obs[2], 32'd102);
    end

    // Flush while FULL with a beat presented
    obs.delete();
    out_ready = 1'b0;
    drive(6'h00, 6'h20, 32'd200, 32'd0);
    @(posedge clk); @(negedge clk);
    drive(6'h00, 6'h20, 32'd201, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    drive(6'h00, 6'h20, 32'd202, 32'd0);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_ovalid", {31'b0, out_valid}, 32'd0);
    chk("fl_iready", {31'b0, in_ready}, 32'd1);

    // Flush in BUSY beats a same-cycle accept
    drive(6'h00, 6'h20, 32'd300, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("fb_ovalid", {31'b0, out_valid}, 32'd1);
    drive(6'h00, 6'h20, 32'd301, 32'd0);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fb_ovalid0", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fl_still_empty", {31'b0, out_valid}, 32'd0);
    chk("fl_no_issue", obs.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX issue stage that feeds the execute-stage ALU. It accepts decoded instruction fields from ID over a valid/ready handshake, encodes the 4-bit ALU control code, and selects and extends operands a/b. Results are registered toward EX through a 2-entry skid buffer, so throughput is one instruction per cycle and in_ready is a registered signal. The ALU consumes a, b and alu_ctrl_op combinationally in EX.

Parameters:
XLEN, 32, operand width
(none other)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill all buffered entries (branch mispredict)
in_valid  in  1  ID presents instruction
in_ready  out  1  stage can accept (registered)
opcode  in  6  instruction opcode
funct  in  6  R-type funct
shamt  in  5  shift amount
imm  in  16  immediate
rs_data  in  XLEN  register rs value
rt_data  in  XLEN  register rt value
out_valid  out  1  EX entry valid
out_ready  in  1  EX accepts
a  out  XLEN  ALU operand a
b  out  XLEN  ALU operand b
alu_ctrl_op  out  4  ALU code
is_branch  out  1  entry is a conditional branch (EX tests ALU z)
illegal  out  1  unknown opcode/funct

Behaviour:
- ALU codes: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SUB, 6 SLTU, 7 NOR, 8 NE-test, 9 GT-test, 10 GE-test, 11 LT-test, 12 LE-test. For codes 8-12, the ALU returns result 0 (z=1) when the named relation holds. For code 5, z=1 when a==b.
- R-type (opcode 0x00): a=rs_data, b=rt_data. funct mapping: 0x24->0; 0x25->1; 0x20/0x21->2; 0x22/0x23->5; 0x2A/0x2B->6 (SLT is executed unsigned; this is a documented limitation); 0x27->7.
- Shifts: funct 0x00->3 and 0x02->4, with a=rt_data and b=zero-extended shamt.
- I-type, sign-extended imm (b=sext(imm), a=rs_data):
  - 0x08/0x09 -> 2
  - 0x0B -> 6
  - 0x23 lw / 0x2B sw -> 2
- I-type, zero-extended imm (b=zext(imm), a=rs_data):
  - 0x0C -> 0
  - 0x0D -> 1
- Branches (is_branch=1, a=rs_data, b=rt_data): 0x04 beq->5, 0x05 bne->8, 0x07 bgt->9, 0x14 bge->10, 0x15 blt->11, 0x06 ble->12.
- Unmapped opcode or funct: alu_ctrl_op=2, a=rs_data, b=rt_data, illegal=1.
- Encoding is computed combinationally from the inputs and captured on acceptance. There is exactly 1 cycle of latency from in_valid&in_ready to out_valid when the buffer is empty.
- Skid FSM (main entry, skid entry):
  - EMPTY: accept -> BUSY.
  - BUSY:
    - accept & !out_ready -> FULL (new entry goes to skid).
    - accept & out_ready -> BUSY (main reloads).
    - !accept & out_ready -> EMPTY.
  - FULL: in_ready=0. out_ready -> BUSY, skid moves to main.
- in_ready is registered and equals 1 in EMPTY/BUSY, 0 in FULL. An in_valid presented while in_ready=0 is ignored.
- Outputs are driven only from the main entry. a/b/alu_ctrl_op/is_branch/illegal hold stable while out_valid & !out_ready.
- flush: next state EMPTY, out_valid=0, in_ready=1. flush dominates a same-cycle accept, and the input beat is dropped.
- rst: same as flush. Additionally a, b, alu_ctrl_op, is_branch and illegal reset to 0. Reset mid-transfer discards both entries.
- out_valid=0 implies the ALU inputs are don't-care, but they still hold their last value (no X propagation).

Decomposition:
- Shared package alu_pkg holds:
  - the ALU code localparams (ALU_AND..ALU_LE);
  - opcode/funct localparams;
  - skid state encoding.
- One natural sub-module is alu_op_encoder: purely combinational, taking opcode/funct/shamt/imm/rs/rt and producing code, a, b, is_branch and illegal. The skid buffer stays in alu_issue_stage.

Test Plan:
- Reset: hold rst 2 cycles -> out_valid=0, in_ready=1, a=b=0, alu_ctrl_op=0. Then send opcode 0x00, funct 0x22, rs=10, rt=3 -> next cycle out_valid=1, code 5, a=10, b=3.
- Extension: addi imm=0xFFFF, rs=5 -> code 2, b=0xFFFFFFFF. ori imm=0xFFFF -> code 1, b=0x0000FFFF. sll shamt=4, rt=1 -> code 3, a=1, b=4.
- Branch encode: opcode 0x07, rs=7, rt=9 -> code 9, is_branch=1. Feeding this to the ALU gives result 1, z=0 (not taken). Opcode 0x15 with the same operands -> code 11, z=1.
- Backpressure: out_ready=0 with 3 back-to-back valid beats -> first two are accepted, in_ready=0 after the second, and the third is held by ID. Raising out_ready drains them in order with no loss or duplication, and outputs stay stable while stalled.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle beat is never issued.
- Illegal: opcode 0x3F -> illegal=1, code 2. R-type funct 0x3E -> illegal=1.
